// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, MEM wait/timeout
// handling and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             miss;
    logic             loaduse;

    // A dropped request while waiting looks exactly like a completed access.
    assign miss    = dmem_req & ~dmem_ready;
    assign loaduse = ex_memread & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (ex_rd == id_rs1)) |
                      (id_use_rs2 & (ex_rd == id_rs2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        pc_en       = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pipe_hold   = 1'b0;
        bus_err     = 1'b0;

        case (state_q)
            S_RUN, S_WAIT: begin
                if (miss) begin
                    pipe_hold  = 1'b1;
                    ifid_stall = 1'b1;
                    if (state_q == S_RUN) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = 8'd1;
                    end else if (wait_cnt_q >= TIMEOUT) begin
                        state_d = S_ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    state_d    = S_RUN;
                    wait_cnt_d = 8'd0;
                    // Redirect outranks load-use: the stalled instruction is wrong-path anyway.
                    if (ex_redirect) begin
                        pc_en      = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (loaduse) begin
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            S_ERR: begin
                bus_err     = 1'b1;
                exmem_flush = 1'b1;
                ifid_stall  = 1'b1;
                state_d     = S_RUN;
                wait_cnt_d  = 8'd0;
            end
            default: begin
                state_d    = S_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase

        // Outputs are combinational, so reset must also quiet them without a clock.
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            pipe_hold   = 1'b0;
            bus_err     = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_en && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if ((ifid_flush | idex_flush | exmem_flush) && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign dbg_state = state_q;

endmodule
